// File: rtl/demux_router.sv
// demux_router
//   1-to-NUM_OUT demultiplexer. Each accepted input word goes to the output
//   channel named by in_sel. Every channel holds one registered entry with its
//   own valid/ready handshake. A word whose select is out of range is always
//   accepted and then discarded; a one-cycle pulse and a saturating counter
//   record each such drop.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous reset, active low
//   in_valid    upstream word valid
//   in_ready    upstream word accepted this cycle (combinational on in_sel/out_ready)
//   in_sel      destination channel index
//   in_data     upstream word
//   out_valid   per-channel entry valid
//   out_ready   per-channel consumer ready
//   out_data    channel k on bits [k*DATA_W +: DATA_W]
//   drop_pulse  high for the cycle after an out-of-range word is accepted
//   drop_count  saturating count of dropped words
module demux_router #(
  parameter int NUM_OUT = 31,
  parameter int DATA_W  = 2,
  parameter int SEL_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SEL_W-1:0]            in_sel,
  input  logic [DATA_W-1:0]           in_data,
  output logic [NUM_OUT-1:0]          out_valid,
  input  logic [NUM_OUT-1:0]          out_ready,
  output logic [NUM_OUT*DATA_W-1:0]   out_data,
  output logic                        drop_pulse,
  output logic [CNT_W-1:0]            drop_count
);

  localparam logic [SEL_W:0]   LP_NUM_OUT = NUM_OUT[SEL_W:0];
  localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;

  logic [NUM_OUT-1:0]        w_hit;
  logic [NUM_OUT-1:0]        w_load;
  logic [NUM_OUT-1:0]        w_drain;
  logic                      w_illegal;
  logic                      w_accept;

  logic [NUM_OUT-1:0]        r_valid;
  logic [NUM_OUT*DATA_W-1:0] r_data;
  logic                      r_drop_pulse;
  logic [CNT_W-1:0]          r_drop_count;

  // Extra top bit so the compare stays correct when NUM_OUT == 2**SEL_W.
  assign w_illegal = ({1'b0, in_sel} >= LP_NUM_OUT);

  // One-hot decode of the select; all zero for an out-of-range select.
  always_comb begin
    w_hit = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      w_hit[k] = (in_sel == k[SEL_W-1:0]);
    end
  end

  // A channel can take a word when it is empty or is being drained this edge,
  // which gives one word per cycle per channel.
  assign in_ready = w_illegal | (|(w_hit & (~r_valid | out_ready)));
  assign w_accept = in_valid & in_ready;
  assign w_load   = {NUM_OUT{w_accept}} & w_hit;
  assign w_drain  = r_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        // Load wins over drain so a same-edge drain and refill keeps valid high.
        if (w_load[k]) begin
          r_valid[k]                    <= 1'b1;
          r_data[k*DATA_W +: DATA_W]    <= in_data;
        end else if (w_drain[k]) begin
          r_valid[k]                    <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_pulse <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_drop_pulse <= w_accept & w_illegal;
      if (w_accept && w_illegal && (r_drop_count != LP_CNT_MAX)) begin
        r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_data   = r_data;
  assign drop_pulse = r_drop_pulse;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_demux_router.sv
module tb_demux_router;

  localparam int NUM_OUT = 31;
  localparam int DATA_W  = 2;
  localparam int SEL_W   = 5;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = 255;

  logic                        clk;
  logic                        rst_n;
  logic                        in_valid;
  logic                        in_ready;
  logic [SEL_W-1:0]            in_sel;
  logic [DATA_W-1:0]           in_data;
  logic [NUM_OUT-1:0]          out_valid;
  logic [NUM_OUT-1:0]          out_ready;
  logic [NUM_OUT*DATA_W-1:0]   out_data;
  logic                        drop_pulse;
  logic [CNT_W-1:0]            drop_count;

  demux_router #(
    .NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop_pulse(drop_pulse),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each channel is a queue of words in flight (capacity 1),
  // dropped words become expected pulses, drop count is a saturating integer.
  logic [DATA_W-1:0] exp_q[NUM_OUT][$];
  bit                drop_q[$];
  int                drop_cnt;

  int n_cmp;
  int n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle, compare DUT against the model, then retire words the
  // consumers take at the coming edge.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [NUM_OUT-1:0] ev;
      logic               er;
      bit                 ep;
      for (int k = 0; k < NUM_OUT; k++) ev[k] = (exp_q[k].size() != 0);
      chk("out_valid", 64'(out_valid), 64'(ev));
      for (int k = 0; k < NUM_OUT; k++) begin
        if (ev[k]) chk($sformatf("out_data[%0d]", k),
                       64'(out_data[k*DATA_W +: DATA_W]), 64'(exp_q[k][0]));
      end
      if (int'(in_sel) >= NUM_OUT) er = 1'b1;
      else er = (exp_q[in_sel].size() == 0) || out_ready[in_sel];
      chk("in_ready", 64'(in_ready), 64'(er));
      ep = (drop_q.size() != 0);
      chk("drop_pulse", 64'(drop_pulse), 64'(ep));
      if (ep) void'(drop_q.pop_front());
      chk("drop_count", 64'(drop_count), 64'(drop_cnt));
      for (int k = 0; k < NUM_OUT; k++) begin
        if (ev[k] && out_ready[k]) void'(exp_q[k].pop_front());
      end
    end
  end

  // One cycle of stimulus: drive at posedge+1, sample handshake mid-cycle,
  // record the expected result at the accepting edge.
  task automatic tick(input logic v, input logic [SEL_W-1:0] s, input logic [DATA_W-1:0] d,
                      input logic [NUM_OUT-1:0] r, output logic acc);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    acc = v && in_ready;
    @(posedge clk);
    if (acc) begin
      if (int'(s) < NUM_OUT) exp_q[s].push_back(d);
      else begin
        drop_q.push_back(1'b1);
        if (drop_cnt < CNT_MAX) drop_cnt++;
      end
    end
    #1;
  endtask

  task automatic flush();
    logic a;
    repeat (2) tick(1'b0, '0, '0, '1, a);
  endtask

  initial begin
    logic              acc;
    logic [NUM_OUT-1:0] r;
    logic              pend;
    logic [SEL_W-1:0]  ps;
    logic [DATA_W-1:0] pd;
    int                waits;

    n_cmp = 0; n_err = 0; drop_cnt = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid",  64'(out_valid),  64'd0);
    chk("rst_out_data",   64'(out_data),   64'd0);
    chk("rst_drop_pulse", 64'(drop_pulse), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word to channel 12 with all consumers stalled.
    tick(1'b1, 5'd12, 2'b10, '0, acc);
    chk("t1_acc", 64'(acc), 64'd1);
    chk("t1_valid", 64'(out_valid), 64'(31'd1 << 12));
    chk("t1_data12", 64'(out_data[12*DATA_W +: DATA_W]), 64'(2'b10));
    flush();

    // Sweep every legal channel with consumers ready.
    for (int s = 0; s < NUM_OUT; s++) begin
      logic [SEL_W-1:0] sv;
      sv = SEL_W'(s);
      tick(1'b1, sv, sv[1:0], '1, acc);
      chk("t2_acc", 64'(acc), 64'd1);
    end
    flush();

    // Full channel 30 blocks, then same-edge drain and reload.
    r = '1; r[30] = 1'b0;
    tick(1'b1, 5'd30, 2'b11, r, acc);
    tick(1'b1, 5'd30, 2'b01, r, acc);
    chk("t3_held", 64'(acc), 64'd0);
    tick(1'b1, 5'd30, 2'b01, '1, acc);
    chk("t3_acc", 64'(acc), 64'd1);
    chk("t3_valid30", 64'(out_valid[30]), 64'd1);
    chk("t3_data30", 64'(out_data[30*DATA_W +: DATA_W]), 64'(2'b01));
    flush();

    // Stalled channel 5 does not block channel 6.
    r = '1; r[5] = 1'b0;
    tick(1'b1, 5'd5, 2'b10, r, acc);
    tick(1'b1, 5'd6, 2'b11, r, acc);
    chk("t4_acc6", 64'(acc), 64'd1);
    chk("t4_valid", 64'(out_valid & ((31'd1 << 5) | (31'd1 << 6))),
        64'((31'd1 << 5) | (31'd1 << 6)));
    chk("t4_data5", 64'(out_data[5*DATA_W +: DATA_W]), 64'(2'b10));
    flush();

    // Illegal selects: always accepted, pulses back to back, count saturates.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 5'b11111, 2'b11, '0, acc);
      chk("t5_acc", 64'(acc), 64'd1);
      chk("t5_pulse", 64'(drop_pulse), 64'd1);
    end
    chk("t5_count3", 64'(drop_count), 64'd3);
    chk("t5_novalid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 300; i++) tick(1'b1, 5'b11111, 2'(i), '0, acc);
    chk("t5_sat", 64'(drop_count), 64'd255);
    flush();
    chk("t5_pulse_off", 64'(drop_pulse), 64'd0);

    // Asynchronous reset mid-cycle with entries held.
    tick(1'b1, 5'd0, 2'b01, '0, acc);
    tick(1'b1, 5'd29, 2'b10, '0, acc);
    chk("t6_loaded", 64'(out_valid), 64'((31'd1 << 29) | 31'd1));
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_data", 64'(out_data), 64'd0);
    chk("t6_count", 64'(drop_count), 64'd0);
    for (int k = 0; k < NUM_OUT; k++) exp_q[k].delete();
    drop_q.delete();
    drop_cnt = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic, holding each word until it is accepted.
    pend = 1'b0; ps = '0; pd = '0; waits = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        ps   = SEL_W'($urandom_range(0, 31));
        pd   = DATA_W'($urandom);
        waits = 0;
      end
      r = NUM_OUT'($urandom) | NUM_OUT'($urandom);
      tick(pend, ps, pd, r, acc);
      if (acc) pend = 1'b0;
      else if (pend && ++waits > 60) begin
        chk("rand_timeout", 64'(acc), 64'd1);
        pend = 1'b0;
      end
    end
    flush();
    begin
      int left;
      left = 0;
      for (int k = 0; k < NUM_OUT; k++) left += exp_q[k].size();
      chk("final_drain", 64'(left), 64'd0);
      chk("final_valid", 64'(out_valid), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
